// File: rtl/cpu_pkg.sv
// Shared types and defaults for the instruction fetch slice: next-PC command
// encodings, fetch FSM states and memory/stack sizing.
package cpu_pkg;

  localparam int IMEM_DEPTH_DEF  = 32;
  localparam int STACK_DEPTH_DEF = 8;
  localparam int XLEN            = 32;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_JUMP   = 2'b01,
    NPC_BRANCH = 2'b10,
    NPC_RET    = 2'b11
  } npc_sel_e;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    HOLD      = 2'd1,
    WAIT_NEXT = 2'd2
  } fetch_state_e;

  // Offsets are unsigned; the add wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_offset(input logic [XLEN-1:0] pc,
                                                input logic [XLEN-1:0] off);
    return pc + off;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the loader write port, the decode handshake, the next-PC command
// and the return-stack status between the fetch unit and its neighbours.
interface fetch_unit_if;

  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [31:0] imem_wdata;

  logic [31:0] ir;
  logic [31:0] pc_out;
  logic        ir_valid;
  logic        ir_ready;

  logic        npc_valid;
  logic [1:0]  npc_sel;
  logic [23:0] imm24;
  logic [13:0] imm14;
  logic        push;
  logic        pop;

  logic        stack_full;
  logic        stack_empty;
  logic        overflow;
  logic        underflow;

  modport master (
    output imem_we, imem_waddr, imem_wdata, ir_ready,
           npc_valid, npc_sel, imm24, imm14, push, pop,
    input  ir, pc_out, ir_valid, stack_full, stack_empty, overflow, underflow
  );

  modport slave (
    input  imem_we, imem_waddr, imem_wdata, ir_ready,
           npc_valid, npc_sel, imm24, imm14, push, pop,
    output ir, pc_out, ir_valid, stack_full, stack_empty, overflow, underflow
  );

endinterface

// File: rtl/return_stack.sv
// Return-address stack: push writes stack[sp] then bumps sp, pop drops sp and
// dout presents the entry below sp combinationally. Error flags are sticky.
module return_stack #(
  parameter int STACK_DEPTH = 8,
  parameter int DATA_W      = 32,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W      = $clog2(STACK_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [SP_W-1:0]   sp,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  logic [DATA_W-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              we;

  assign full  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty = (sp_q == '0);

  // Simultaneous push and pop is treated as a protocol error: no movement.
  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we    = 1'b0;
    if (push && pop) begin
      ovf_d = 1'b1;
      unf_d = 1'b1;
    end else if (push) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        we   = 1'b1;
        sp_d = sp_q + SP_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        sp_d = sp_q - SP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) stack_q[IDX_W'(sp_q)] <= din;
  end

  assign dout      = stack_q[IDX_W'(sp_q - SP_W'(1))];
  assign sp        = sp_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads imem at the PC, hands the word to decode with a
// valid/ready handshake, then waits for the next-PC command.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int IMEM_DEPTH  = IMEM_DEPTH_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.slave  bus
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);

  logic [XLEN-1:0] imem [IMEM_DEPTH];

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            ir_valid_q, ir_valid_d;

  logic            stk_push, stk_pop, pop_ok;
  logic [XLEN-1:0] stk_dout;
  logic [SP_W-1:0] stk_sp;
  logic            stk_full, stk_empty, stk_ovf, stk_unf;
  logic            cmd_fire;
  npc_sel_e        sel;

  // Loader port; not reset so program contents survive a core reset.
  always_ff @(posedge clk) begin
    if (bus.imem_we) imem[bus.imem_waddr[IDX_W-1:0]] <= bus.imem_wdata;
  end

  assign sel      = npc_sel_e'(bus.npc_sel);
  assign cmd_fire = (state_q == WAIT_NEXT) && bus.npc_valid;
  assign pop_ok   = bus.pop && !bus.push && (stk_sp != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      pc_out_q   <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      pc_out_q   <= pc_out_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:     state_d = HOLD;
      HOLD:      if (ir_valid_q && bus.ir_ready) state_d = WAIT_NEXT;
      WAIT_NEXT: if (bus.npc_valid) state_d = FETCH;
      default:   state_d = FETCH;
    endcase
  end

  // The memory read sees the pre-edge array, so a same-cycle write to the
  // fetched address returns the old word.
  always_comb begin
    ir_d       = ir_q;
    pc_out_d   = pc_out_q;
    ir_valid_d = ir_valid_q;
    pc_d       = pc_q;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    unique case (state_q)
      FETCH: begin
        ir_d       = imem[pc_q[IDX_W-1:0]];
        pc_out_d   = pc_q;
        ir_valid_d = 1'b1;
      end
      HOLD: begin
        if (ir_valid_q && bus.ir_ready) ir_valid_d = 1'b0;
      end
      WAIT_NEXT: begin
        if (cmd_fire) begin
          stk_push = bus.push;
          stk_pop  = bus.pop;
          unique case (sel)
            NPC_SEQ:    pc_d = pc_offset(pc_q, 32'd1);
            NPC_JUMP:   pc_d = pc_offset(pc_q, {8'd0, bus.imm24});
            NPC_BRANCH: pc_d = pc_offset(pc_q, {18'd0, bus.imm14});
            NPC_RET:    pc_d = pop_ok ? pc_offset(stk_dout, 32'd1)
                                      : pc_offset(pc_q, 32'd1);
            default:    pc_d = pc_offset(pc_q, 32'd1);
          endcase
        end
      end
      default: ;
    endcase
  end

  return_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .DATA_W      (XLEN)
  ) u_return_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .din       (pc_q),
    .dout      (stk_dout),
    .sp        (stk_sp),
    .full      (stk_full),
    .empty     (stk_empty),
    .overflow  (stk_ovf),
    .underflow (stk_unf)
  );

  assign bus.ir          = ir_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.ir_valid    = ir_valid_q;
  assign bus.stack_full  = stk_full;
  assign bus.stack_empty = stk_empty;
  assign bus.overflow    = stk_ovf;
  assign bus.underflow   = stk_unf;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter IMEM_DEPTH, default 32, meaning instruction words held; PC indexes with pc[4:0].
REQ-002 The block SHALL have parameter STACK_DEPTH, default 8, meaning return-address entries.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port imem_we / imem_waddr / imem_wdata, input, 1/5/32 bits, the bench/loader write port into instruction memory.
REQ-006 The block SHALL have port ir, output, 32 bits, the fetched instruction word.
REQ-007 The block SHALL have port pc_out, output, 32 bits, the PC of the word on ir.
REQ-008 The block SHALL have ports ir_valid (output, 1) and ir_ready (input, 1), the instruction handshake to decode.
REQ-009 The block SHALL have ports npc_valid (input, 1) and npc_sel (input, 2), the next-PC command: 00 PC+1, 01 jump, 10 branch, 11 return.
REQ-010 The block SHALL have ports imm24 and imm14, inputs, 24 and 14 bits, the jump and branch offsets.
REQ-011 The block SHALL have ports push and pop, inputs, 1 bit each, the return-stack controls sampled with npc_valid.
REQ-012 The block SHALL have ports stack_full, stack_empty, overflow and underflow, outputs, 1 bit each; overflow and underflow are sticky error flags.

Function
REQ-013 The FSM SHALL have states FETCH, HOLD and WAIT_NEXT.
REQ-014 In FETCH, the block SHALL load ir from imem[pc[4:0]], set ir_valid=1 and go to HOLD, so ir is valid one cycle after entry.
REQ-015 In HOLD, the block SHALL hold ir, pc_out and ir_valid stable until ir_valid&&ir_ready, then clear ir_valid and go to WAIT_NEXT.
REQ-016 In WAIT_NEXT, on npc_valid the block SHALL update PC per npc_sel, apply push/pop and go to FETCH; it SHALL stay in WAIT_NEXT otherwise.
REQ-017 Command 00 SHALL set PC = PC+1.
REQ-018 Command 01 SHALL set PC = PC + zero-extended imm24.
REQ-019 Command 10 SHALL set PC = PC + zero-extended imm14.
REQ-020 Command 11 SHALL set PC = popped value + 1.
REQ-021 All PC arithmetic SHALL be 32-bit modulo 2^32, and the imem index SHALL wrap via pc[4:0].
REQ-022 A push SHALL store the current PC (the JAL's own address) at stack[sp] and then increment sp.
REQ-023 A pop SHALL decrement sp and then read stack[sp].
REQ-024 A push when full SHALL leave the stack unchanged and set overflow; the PC update still occurs.
REQ-025 A pop when empty SHALL set underflow; sel 11 then yields PC+1.
REQ-026 Push and pop asserted together SHALL leave the stack unchanged and set both overflow and underflow; the PC follows npc_sel, with sel 11 treated as 00.
REQ-027 npc_valid outside WAIT_NEXT SHALL be ignored.
REQ-028 An imem write to the address being fetched in the same cycle SHALL return the old word on ir.
REQ-029 stack_full SHALL equal (sp==STACK_DEPTH) and stack_empty SHALL equal (sp==0); both are combinational from sp.

Reset
REQ-030 On reset, the block SHALL set PC=0, ir=0, pc_out=0, ir_valid=0, sp=0, overflow=0, underflow=0 and state=FETCH on the next edge.
REQ-031 Reset asserted in any state, including mid-handshake, SHALL abandon the transfer; imem contents SHALL be preserved.

Structure
REQ-032 Package cpu_pkg SHALL hold the npc_sel encodings, the FSM state enum, IMEM_DEPTH and STACK_DEPTH defaults.
REQ-033 The return stack SHALL be a sub-module return_stack (push, pop, din, dout, sp, full, empty, overflow, underflow).

Verification
REQ-034 The bench SHALL cover: reset, imem[0]=32'h10040034 -> ir=32'h10040034, pc_out=0, ir_valid=1 two edges after reset release.
REQ-035 The bench SHALL cover: ir_ready held 0 for 5 cycles -> ir/pc_out stable, ir_valid=1; ready=1 -> ir_valid=0 next cycle.
REQ-036 The bench SHALL cover: PC=8, sel=01, imm24=12, push=1 -> PC=20, stack[0]=8, sp=1; later sel=11, pop=1 -> PC=9, sp=0.
REQ-037 The bench SHALL cover: 9 consecutive pushes -> sp=8, stack_full=1, overflow=1 after the 9th, and stack[7] is unchanged.
REQ-038 The bench SHALL cover: pop with sp=0 at PC=4 and sel=11 -> PC=5, underflow=1; PC=32'hFFFFFFFF, sel=00 -> PC=0, fetch from imem[0].
REQ-039 The bench SHALL cover: reset asserted while in HOLD -> ir_valid=0, PC=0 next cycle; imem unchanged.
